matmul_stream_sequencer: RTL and testbench

Streaming front-end and initiator for the `matrix_multiplication` engine. It accepts Q20.12 elements of A and then B one word per cycle over a valid/ready stream and packs them row-major into the engine's 1152-bit operand buses. It drives the engine's start/done handshake, captures the packed result and streams C back out row-major with a last marker. It sits between the host/DMA stream fabric and the multiplier, replacing hand-built pack/unpack logic.

---
 rtl/matmul_pkg.sv | 28 ++
 rtl/matmul_bus_packer.sv | 30 +++
 rtl/matmul_stream_sequencer.sv | 158 +++++++++++++++
 tb/tb_matmul_stream_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and dimension checks for the matrix-multiply
// sequencer and engine.
package matmul_pkg;
  localparam int ELEM_W    = 32;
  localparam int FRAC_W    = 12;
  localparam int MAX_DIM   = 6;
  localparam int NUM_SLOTS = MAX_DIM * MAX_DIM;
  localparam int BUS_W     = ELEM_W * NUM_SLOTS;
  localparam int IDX_W     = $clog2(NUM_SLOTS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_A    = 3'd1,
    ST_LOAD_B    = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_DRAIN     = 3'd6
  } seq_state_t;

  function automatic logic dim_ok(input logic [7:0] d);
    return (d != 8'd0) && (d <= 8'(MAX_DIM));
  endfunction

  function automatic logic cfg_ok(input logic [7:0] r, input logic [7:0] i, input logic [7:0] c);
    return dim_ok(r) && dim_ok(i) && dim_ok(c);
  endfunction
endpackage

// File: rtl/matmul_bus_packer.sv
// Write-indexed 36x32 register bank exposed as one packed operand bus.
// Single-cycle write; a write to a slot wins over a same-cycle clear.
module matmul_bus_packer
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ELEM_W-1:0] wr_data,
  output logic [BUS_W-1:0]  bus
);
  logic [ELEM_W-1:0] slot [NUM_SLOTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_SLOTS; n++) slot[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_SLOTS; n++) begin
        if (wr_en && wr_idx == IDX_W'(n)) slot[n] <= wr_data;
        else if (clear)                   slot[n] <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bus[g*ELEM_W +: ELEM_W] = slot[g];
  end
endmodule

// File: rtl/matmul_stream_sequencer.sv
// Streams A then B into packed operand buses, runs the engine start/done handshake,
// then streams C out row-major; input stalls while the engine runs, output honours out_ready.
module matmul_stream_sequencer
  import matmul_pkg::*;
#(
  parameter int TIMEOUT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cfg_rows,
  input  logic [7:0]        cfg_inner,
  input  logic [7:0]        cfg_cols,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic              mm_start,
  input  logic              mm_done,
  output logic [7:0]        mm_rowsA,
  output logic [7:0]        mm_colsA,
  output logic [7:0]        mm_colsB,
  output logic [BUS_W-1:0]  mm_Ain,
  output logic [BUS_W-1:0]  mm_Bin,
  input  logic [BUS_W-1:0]  mm_Cout
);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  seq_state_t        state;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  m;
  logic [TCNT_W-1:0] tcnt;
  logic              timed_out;
  logic [BUS_W-1:0]  c_reg;
  logic [IDX_W-1:0]  a_total, b_total, c_total;
  logic [10:0]       c_base;
  logic              cfg_legal, accept, start_job, a_wr, b_wr;

  // Latched dimensions are always legal, so the low three bits carry the value.
  assign a_total = {3'b000, mm_rowsA[2:0]} * {3'b000, mm_colsA[2:0]};
  assign b_total = {3'b000, mm_colsA[2:0]} * {3'b000, mm_colsB[2:0]};
  assign c_total = {3'b000, mm_rowsA[2:0]} * {3'b000, mm_colsB[2:0]};

  assign cfg_legal = cfg_ok(cfg_rows, cfg_inner, cfg_cols);
  assign in_ready  = (state == ST_IDLE) || (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign accept    = in_valid && in_ready;
  assign start_job = accept && (state == ST_IDLE) && cfg_legal;
  assign a_wr      = start_job || (accept && state == ST_LOAD_A);
  assign b_wr      = accept && (state == ST_LOAD_B);

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DRAIN);
  assign out_last  = out_valid && (m == c_total - IDX_W'(1));
  assign c_base    = {m, 5'd0};
  assign out_data  = out_valid ? c_reg[c_base +: ELEM_W] : '0;

  // cnt is zero whenever the FSM sits in IDLE, so the first word lands in slot 0.
  matmul_bus_packer u_pack_a (
    .clk(clk), .rst(rst), .clear(start_job), .wr_en(a_wr),
    .wr_idx(cnt), .wr_data(in_data), .bus(mm_Ain)
  );

  matmul_bus_packer u_pack_b (
    .clk(clk), .rst(rst), .clear(start_job), .wr_en(b_wr),
    .wr_idx(cnt), .wr_data(in_data), .bus(mm_Bin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      m         <= '0;
      tcnt      <= '0;
      timed_out <= 1'b0;
      c_reg     <= '0;
      mm_start  <= 1'b0;
      err       <= 1'b0;
      mm_rowsA  <= '0;
      mm_colsA  <= '0;
      mm_colsB  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          if (!cfg_legal) begin
            err <= 1'b1;
          end else begin
            mm_rowsA  <= cfg_rows;
            mm_colsA  <= cfg_inner;
            mm_colsB  <= cfg_cols;
            timed_out <= 1'b0;
            if (cfg_rows == 8'd1 && cfg_inner == 8'd1) begin
              cnt   <= '0;
              state <= ST_LOAD_B;
            end else begin
              cnt   <= IDX_W'(1);
              state <= ST_LOAD_A;
            end
          end
        end
        ST_LOAD_A: if (accept) begin
          if (cnt == a_total - IDX_W'(1)) begin
            cnt   <= '0;
            state <= ST_LOAD_B;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        ST_LOAD_B: if (accept) begin
          if (cnt == b_total - IDX_W'(1)) begin
            cnt      <= '0;
            mm_start <= 1'b1;
            tcnt     <= '0;
            state    <= ST_START;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        // tcnt counts cycles with mm_start high, starting at 0 in the START cycle.
        ST_START: begin
          tcnt  <= tcnt + TCNT_W'(1);
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (mm_done) begin
            c_reg    <= mm_Cout;
            mm_start <= 1'b0;
            state    <= ST_RELEASE;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            mm_start  <= 1'b0;
            timed_out <= 1'b1;
            state     <= ST_RELEASE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ST_RELEASE: if (!mm_done) begin
          m     <= '0;
          state <= timed_out ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: if (out_ready) begin
          if (m == c_total - IDX_W'(1)) begin
            m     <= '0;
            state <= ST_IDLE;
          end else begin
            m <= m + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_stream_sequencer.sv
// Scoreboard bench for matmul_stream_sequencer with a behavioural engine model.
module tb_matmul_stream_sequencer;
  import matmul_pkg::*;

  localparam int TIMEOUT = 512;
  localparam int ENG_LAT = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        cfg_rows, cfg_inner, cfg_cols;
  logic              in_valid, in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              out_valid, out_ready, out_last;
  logic [ELEM_W-1:0] out_data;
  logic              busy, err, mm_start, mm_done;
  logic [7:0]        mm_rowsA, mm_colsA, mm_colsB;
  logic [BUS_W-1:0]  mm_Ain, mm_Bin, mm_Cout;

  always #5 clk = ~clk;

  matmul_stream_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_rows(cfg_rows), .cfg_inner(cfg_inner), .cfg_cols(cfg_cols),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err), .mm_start(mm_start), .mm_done(mm_done),
    .mm_rowsA(mm_rowsA), .mm_colsA(mm_colsA), .mm_colsB(mm_colsB),
    .mm_Ain(mm_Ain), .mm_Bin(mm_Bin), .mm_Cout(mm_Cout)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } out_t;

  int         checks = 0;
  int         failures = 0;
  out_t       exp_q[$];
  logic       eng_hang = 1'b0;
  int         or_mode = 0;
  logic [7:0] exp_rows = 8'd0, exp_inner = 8'd0, exp_cols = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [BUS_W-1:0] engine_mul(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b,
                                                 input int r, input int n, input int c);
    logic [BUS_W-1:0] res;
    longint acc;
    res = '0;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++)
          acc += longint'($signed(a[(i*n+k)*ELEM_W +: ELEM_W])) * longint'($signed(b[(k*c+j)*ELEM_W +: ELEM_W]));
        res[(i*c+j)*ELEM_W +: ELEM_W] = 32'(acc >>> FRAC_W);
      end
    return res;
  endfunction

  // Engine model: raises done ENG_LAT cycles after start, holds it until start drops.
  initial begin : engine
    int eng_cnt;
    eng_cnt = 0;
    mm_done = 1'b0;
    mm_Cout = '0;
    forever begin
      @(negedge clk);
      if (rst || !mm_start) begin
        mm_done = 1'b0;
        eng_cnt = 0;
      end else if (!mm_done && !eng_hang) begin
        eng_cnt++;
        if (eng_cnt == ENG_LAT) begin
          check("eng_rows", 64'(mm_rowsA), 64'(exp_rows));
          check("eng_inner", 64'(mm_colsA), 64'(exp_inner));
          check("eng_cols", 64'(mm_colsB), 64'(exp_cols));
          mm_Cout = engine_mul(mm_Ain, mm_Bin, int'(mm_rowsA), int'(mm_colsA), int'(mm_colsB));
          mm_done = 1'b1;
        end
      end
    end
  end

  initial begin : ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold under backpressure.
  logic        held = 1'b0;
  logic [31:0] held_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) check("hold_data", 64'(out_data), 64'(held_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=none", out_data);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  task automatic set_cfg(input logic [7:0] r, input logic [7:0] i, input logic [7:0] c);
    cfg_rows = r; cfg_inner = i; cfg_cols = c;
    exp_rows = r; exp_inner = i; exp_cols = c;
  endtask

  task automatic send(input logic [31:0] d, input int gapmax);
    int   budget;
    logic rdy;
    budget = 0;
    in_valid = 1'b1;
    in_data = d;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 200) begin
        check("send_timeout", 64'(rdy), 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      n++;
    end
    check({name, "_complete"}, 64'(n < 3000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_in_ready"}, 64'(in_ready), 64'd1);
    check({p, "_out_valid"}, 64'(out_valid), 64'd0);
    check({p, "_out_last"}, 64'(out_last), 64'd0);
    check({p, "_out_data"}, 64'(out_data), 64'd0);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_err"}, 64'(err), 64'd0);
    check({p, "_mm_start"}, 64'(mm_start), 64'd0);
    check({p, "_ain_nonzero"}, 64'(|mm_Ain), 64'd0);
    check({p, "_bin_nonzero"}, 64'(|mm_Bin), 64'd0);
    check({p, "_rowsA"}, 64'(mm_rowsA), 64'd0);
    check({p, "_colsA"}, 64'(mm_colsA), 64'd0);
    check({p, "_colsB"}, 64'(mm_colsB), 64'd0);
  endtask

  task automatic offer_illegal(input logic [7:0] c, input int nw, input string name);
    int errs, starts, busys;
    errs = 0; starts = 0; busys = 0;
    cfg_rows = 8'd2; cfg_inner = 8'd2; cfg_cols = c;
    in_data = 32'h1234;
    in_valid = 1'b1;
    for (int i = 0; i < nw + 2; i++) begin
      @(negedge clk);
      errs += int'(err);
      starts += int'(mm_start);
      busys += int'(busy);
      @(posedge clk);
      #1;
      if (i == nw - 1) in_valid = 1'b0;
    end
    check({name, "_err_pulses"}, 64'(errs), 64'(nw));
    check({name, "_mm_start"}, 64'(starts), 64'd0);
    check({name, "_busy"}, 64'(busys), 64'd0);
  endtask

  task automatic run_1x1(input string name);
    exp_q.push_back('{data: 32'h6000, last: 1'b1});
    set_cfg(8'd1, 8'd1, 8'd1);
    send(32'h2000, 0);
    send(32'h3000, 0);
    wait_idle(name);
  endtask

  initial begin : watchdog
    #400000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] bvals [36];
    logic [31:0] slot_exp;
    int   n;
    logic prev_start, seen;

    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_rows = '0; cfg_inner = '0; cfg_cols = '0;
    #1 rst = 1'b1;
    #2 check_reset_vals("reset");
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // 2x3 * 3x2 with integer operands; cfg changes after the first word must be ignored.
    set_cfg(8'd2, 8'd3, 8'd2);
    exp_q.push_back('{data: 32'h16000, last: 1'b0});
    exp_q.push_back('{data: 32'h1C000, last: 1'b0});
    exp_q.push_back('{data: 32'h31000, last: 1'b0});
    exp_q.push_back('{data: 32'h40000, last: 1'b1});
    for (int i = 0; i < 6; i++) begin
      send(32'(i + 1) << 12, 0);
      if (i == 0) cfg_rows = 8'd5;
    end
    for (int i = 0; i < 5; i++) send(32'(i + 1) << 12, 0);
    check("mm_start_before_last_b", 64'(mm_start), 64'd0);
    send(32'h6000, 0);
    @(negedge clk);
    check("mm_start_after_last_b", 64'(mm_start), 64'd1);
    check("in_ready_in_start", 64'(in_ready), 64'd0);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_exp = (i < 6) ? 32'(i + 1) << 12 : 32'd0;
      check($sformatf("ain_slot%0d", i), 64'(mm_Ain[i*ELEM_W +: ELEM_W]), 64'(slot_exp));
      check($sformatf("bin_slot%0d", i), 64'(mm_Bin[i*ELEM_W +: ELEM_W]), 64'(slot_exp));
    end
    check("dim_rowsA", 64'(mm_rowsA), 64'd2);
    @(posedge clk);
    #1;
    wait_idle("job2x3");

    // 6x6 identity times random B, with input gaps and output backpressure.
    set_cfg(8'd6, 8'd6, 8'd6);
    or_mode = 1;
    for (int i = 0; i < 36; i++) begin
      bvals[i] = $urandom();
      exp_q.push_back('{data: bvals[i], last: (i == 35)});
    end
    for (int i = 0; i < 36; i++) send(((i / 6) == (i % 6)) ? 32'h1000 : 32'h0, 2);
    for (int i = 0; i < 36; i++) send(bvals[i], 2);
    wait_idle("identity");
    or_mode = 0;

    // Illegal configurations are rejected word by word.
    offer_illegal(8'd0, 3, "cols0");
    offer_illegal(8'd7, 2, "cols7");

    // Engine never finishes: timeout error, no output, then a normal job.
    eng_hang = 1'b1;
    set_cfg(8'd1, 8'd1, 8'd1);
    send(32'h1000, 0);
    send(32'h1000, 0);
    n = -1; prev_start = 1'b0; seen = 1'b0;
    for (int t = 0; t < TIMEOUT + 50; t++) begin
      @(negedge clk);
      if (n < 0 && mm_start) n = 0;
      else if (n >= 0) n++;
      if (n >= 0 && err) begin
        seen = 1'b1;
        break;
      end
      prev_start = mm_start;
    end
    check("timeout_err_seen", 64'(seen), 64'd1);
    check("timeout_cycle", 64'(n), 64'(TIMEOUT));
    check("timeout_start_held", 64'(prev_start), 64'd1);
    check("timeout_start_drop", 64'(mm_start), 64'd0);
    @(negedge clk);
    check("timeout_err_one_cycle", 64'(err), 64'd0);
    eng_hang = 1'b0;
    wait_idle("timeout");

    // 1x1 job: the single A word skips straight to LOAD_B.
    exp_q.push_back('{data: 32'h6000, last: 1'b1});
    set_cfg(8'd1, 8'd1, 8'd1);
    in_valid = 1'b1;
    in_data = 32'h2000;
    @(negedge clk);
    check("t11_start_c0", 64'(mm_start), 64'd0);
    @(posedge clk);
    #1 in_data = 32'h3000;
    @(negedge clk);
    check("t11_busy_c1", 64'(busy), 64'd1);
    check("t11_start_c1", 64'(mm_start), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t11_start_c2", 64'(mm_start), 64'd1);
    wait_idle("t11");

    // Reset while waiting on the engine.
    eng_hang = 1'b1;
    set_cfg(8'd1, 8'd1, 8'd1);
    send(32'h5000, 0);
    send(32'h7000, 0);
    repeat (20) @(negedge clk);
    check("wd_start_high", 64'(mm_start), 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_vals("rst_wait");
    #1 rst = 1'b0;
    eng_hang = 1'b0;
    @(posedge clk);
    #1;

    // Reset while draining with the output stalled.
    or_mode = 2;
    set_cfg(8'd2, 8'd3, 8'd2);
    for (int i = 0; i < 12; i++) send(32'((i % 6) + 1) << 12, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_reached", 64'(out_valid), 64'd1);
    check("drain_first_data", 64'(out_data), 64'h16000);
    check("drain_first_last", 64'(out_last), 64'd0);
    #1 rst = 1'b1;
    #1 check_reset_vals("rst_drain");
    #1 rst = 1'b0;
    or_mode = 0;
    @(posedge clk);
    #1;
    run_1x1("post_reset_1x1");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
